// File: rtl/sram_banked_ctrl.sv
// Word-addressed on-chip SRAM with per-lane write enables, Req/Ready handshake,
// post-reset clear sequencer and a shared tristate data bus.
`timescale 1ns/1ps
module sram_banked_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LANE_W     = 16,
  parameter int unsigned ADDR_W     = 11,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic                       Clock1,
  input  logic                       RST,
  input  logic                       Req,
  input  logic                       RNW,
  input  logic [ADDR_W-1:0]          AdxBus,
  input  logic [DATA_W/LANE_W-1:0]   LaneEn,
  input  logic                       OE,
  inout  wire  [DATA_W-1:0]          DataBus,
  output logic                       Ready,
  output logic                       Valid,
  output logic                       Busy
);

  localparam int unsigned NL    = DATA_W / LANE_W;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {CLEAR, IDLE, ACCESS} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [ADDR_W-1:0]   mar;
  logic                op_rd;
  logic [NL-1:0]       le;
  logic [DATA_W-1:0]   mdr;
  logic                rd_hold;
  logic                accept;

  logic [NL-1:0]       mem_we;
  logic [ADDR_W-1:0]   mem_wa;
  logic [DATA_W-1:0]   mem_wd;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Ready is registered so it stays low through reset even when the block
  // comes out of reset directly in IDLE; acceptance is keyed on it.
  assign accept = Ready && Req;

  always_comb begin
    state_nxt = state;
    unique case (state)
      CLEAR:   if (clr_cnt == '1) state_nxt = IDLE;
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single write port shared by the clear sequencer and committed writes.
  always_comb begin
    mem_we = '0;
    mem_wa = '0;
    mem_wd = '0;
    if (state == CLEAR) begin
      mem_we = '1;
      mem_wa = clr_cnt;
    end else if (state == ACCESS && !op_rd) begin
      mem_we = le;
      mem_wa = mar;
      mem_wd = mdr;
    end
  end

  always_ff @(posedge Clock1) begin
    if (RST) begin
      for (int unsigned i = 0; i < NL; i++) begin
        if (mem_we[i]) mem[mem_wa][i*LANE_W +: LANE_W] <= mem_wd[i*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge Clock1) begin
    if (!RST) begin
      state   <= INIT_CLEAR ? CLEAR : IDLE;
      clr_cnt <= '0;
      mar     <= '0;
      op_rd   <= 1'b0;
      le      <= '0;
      mdr     <= '0;
      rd_hold <= 1'b0;
      Ready   <= 1'b0;
      Valid   <= 1'b0;
      Busy    <= INIT_CLEAR;
    end else begin
      state <= state_nxt;
      Ready <= (state_nxt == IDLE);
      Busy  <= (state_nxt == CLEAR);
      Valid <= (state == ACCESS) && op_rd;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (accept) begin
        mar     <= AdxBus;
        op_rd   <= RNW;
        le      <= LaneEn;
        rd_hold <= 1'b0;
        if (!RNW) mdr <= DataBus;
      end
      if (state == ACCESS && op_rd) begin
        mdr     <= mem[mar];
        rd_hold <= 1'b1;
      end
    end
  end

  assign DataBus = (!OE && rd_hold) ? mdr : 'z;

endmodule

// File: tb/tb_sram_banked_ctrl.sv
// Directed bench for sram_banked_ctrl: clear sequence, lane writes, handshake,
// reset abort and bus tristate behaviour.
`timescale 1ns/1ps
module tb_sram_banked_ctrl;

  logic        Clock1 = 1'b0;
  logic        RST = 1'b0;
  logic        Req = 1'b0;
  logic        RNW = 1'b1;
  logic [10:0] AdxBus = '0;
  logic [1:0]  LaneEn = '0;
  logic        OE = 1'b1;
  logic        tb_drv = 1'b0;
  logic [31:0] tb_data = '0;
  wire  [31:0] DataBus;
  logic        Ready, Valid, Busy;

  int n_cmp = 0;
  int n_bad = 0;

  assign DataBus = tb_drv ? tb_data : 'z;

  sram_banked_ctrl #(.DATA_W(32), .LANE_W(16), .ADDR_W(11), .INIT_CLEAR(1'b1)) dut (
    .Clock1(Clock1), .RST(RST), .Req(Req), .RNW(RNW), .AdxBus(AdxBus),
    .LaneEn(LaneEn), .OE(OE), .DataBus(DataBus),
    .Ready(Ready), .Valid(Valid), .Busy(Busy)
  );

  always #5 Clock1 = ~Clock1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge Clock1);
    #1;
  endtask

  task automatic wait_ready(input int limit);
    int n = 0;
    while (Ready !== 1'b1 && n < limit) begin
      tick;
      n++;
    end
    n_cmp++;
    if (Ready !== 1'b1) begin
      n_bad++;
      $display("FAIL wait_ready: Ready=%b after %0d cycles, required 1", Ready, n);
    end
  endtask

  // Presents one request on a Ready cycle; returns just after the accepting edge.
  task automatic start_op(input logic rnw, input logic [10:0] a, input logic [31:0] d,
                          input logic [1:0] le);
    wait_ready(16);
    Req = 1'b1; RNW = rnw; AdxBus = a; LaneEn = le; OE = 1'b1;
    tb_drv = !rnw; tb_data = d;
    tick;
    Req = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic write_word(input logic [10:0] a, input logic [31:0] d, input logic [1:0] le);
    start_op(1'b0, a, d, le);
    tick;
  endtask

  task automatic read_word(input logic [10:0] a, output logic [31:0] d, output logic v);
    start_op(1'b1, a, '0, '0);
    tick;
    v = Valid;
    OE = 1'b0;
    #1 d = DataBus;
    OE = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    int n = 0;
    logic bad_busy = 1'b0;
    logic [31:0] d;
    logic v;
    RST = 1'b0;
    tick; tick;
    n_cmp++;
    if (Ready !== 1'b0 || Busy !== 1'b1 || Valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: Ready/Busy/Valid=%b%b%b, required 010", Ready, Busy, Valid);
    end
    RST = 1'b1;
    do begin
      tick;
      n++;
      if (Ready !== 1'b1 && Busy !== 1'b1) bad_busy = 1'b1;
    end while (Ready !== 1'b1 && n < 3000);
    n_cmp++;
    if (n != 2048 || bad_busy) begin
      n_bad++;
      $display("FAIL clear_len: Ready after %0d cycles (busy_drop=%b), required 2048 (0)", n, bad_busy);
    end
    n_cmp++;
    if (Busy !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_busy: Busy=%b, required 0", Busy);
    end
    read_word(11'h7FF, d, v);
    n_cmp++;
    if (v !== 1'b1 || d !== 32'h0000_0000) begin
      n_bad++;
      $display("FAIL clear_top: valid=%b data=%h, required 1 00000000", v, d);
    end
  endtask

  task automatic test_full_rw;
    start_op(1'b0, 11'd5, 32'hDEAD_BEEF, 2'b11);
    n_cmp++;
    if (Ready !== 1'b0 || Valid !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_accept: Ready/Valid=%b%b, required 00", Ready, Valid);
    end
    tick;
    n_cmp++;
    if (Ready !== 1'b1 || Valid !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_commit: Ready/Valid=%b%b, required 10", Ready, Valid);
    end
    start_op(1'b1, 11'd5, '0, '0);
    n_cmp++;
    if (Valid !== 1'b0 || Ready !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_accept: Ready/Valid=%b%b, required 00", Ready, Valid);
    end
    tick;
    OE = 1'b0;
    #1;
    n_cmp++;
    if (Valid !== 1'b1 || DataBus !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL rd_full: valid=%b bus=%h, required 1 deadbeef", Valid, DataBus);
    end
    tick;
    n_cmp++;
    if (Valid !== 1'b0) begin
      n_bad++;
      $display("FAIL valid_pulse: Valid=%b one cycle later, required 0", Valid);
    end
    OE = 1'b1;
  endtask

  task automatic test_lanes;
    logic [31:0] d;
    logic v;
    write_word(11'd5, 32'h1234_5678, 2'b01);
    read_word(11'd5, d, v);
    n_cmp++;
    if (d !== 32'hDEAD_5678) begin
      n_bad++;
      $display("FAIL lane_lo: data=%h, required dead5678", d);
    end
    write_word(11'd5, 32'hFFFF_FFFF, 2'b00);
    read_word(11'd5, d, v);
    n_cmp++;
    if (d !== 32'hDEAD_5678) begin
      n_bad++;
      $display("FAIL lane_none: data=%h, required dead5678", d);
    end
    write_word(11'd5, 32'hCAFE_0000, 2'b10);
    read_word(11'd5, d, v);
    n_cmp++;
    if (d !== 32'hCAFE_5678) begin
      n_bad++;
      $display("FAIL lane_hi: data=%h, required cafe5678", d);
    end
    write_word(11'h7FF, 32'h0BAD_F00D, 2'b11);
    read_word(11'h7FF, d, v);
    n_cmp++;
    if (d !== 32'h0BAD_F00D) begin
      n_bad++;
      $display("FAIL top_addr: data=%h, required 0badf00d", d);
    end
    read_word(11'h000, d, v);
    n_cmp++;
    if (d !== 32'h0000_0000) begin
      n_bad++;
      $display("FAIL no_alias: addr0 data=%h, required 00000000", d);
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] adr [5]   = '{11'd20, 11'd21, 11'd22, 11'd21, 11'd20};
    logic        rdy [5]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        vld [5]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] dat [5]   = '{32'h0, 32'h1111_2222, 32'h0, 32'h5555_6666, 32'h0};
    write_word(11'd20, 32'h1111_2222, 2'b11);
    write_word(11'd21, 32'h7777_8888, 2'b11);
    write_word(11'd22, 32'h5555_6666, 2'b11);
    wait_ready(16);
    OE = 1'b0; Req = 1'b1; RNW = 1'b1;
    for (int k = 0; k < 5; k++) begin
      AdxBus = adr[k];
      #1;
      n_cmp++;
      if (Ready !== rdy[k]) begin
        n_bad++;
        $display("FAIL b2b_ready[%0d]: Ready=%b, required %b", k, Ready, rdy[k]);
      end
      tick;
      n_cmp++;
      if (Valid !== vld[k] || (vld[k] && DataBus !== dat[k])) begin
        n_bad++;
        $display("FAIL b2b_valid[%0d]: Valid=%b bus=%h, required %b %h", k, Valid, DataBus, vld[k], dat[k]);
      end
    end
    Req = 1'b0; OE = 1'b1;
    tick;
  endtask

  task automatic test_tristate;
    logic [31:0] d;
    logic v;
    read_word(11'd22, d, v);
    tb_drv = 1'b1; tb_data = 32'h0; OE = 1'b1;
    #1;
    n_cmp++;
    if (DataBus !== 32'h0) begin
      n_bad++;
      $display("FAIL ts_oe_high: bus=%h with probe 0, required 00000000", DataBus);
    end
    tb_drv = 1'b0; OE = 1'b0;
    tick; tick;
    n_cmp++;
    if (DataBus !== 32'h5555_6666) begin
      n_bad++;
      $display("FAIL ts_persist: bus=%h, required 55556666", DataBus);
    end
    start_op(1'b0, 11'd23, 32'h0F0F_0F0F, 2'b11);
    tb_drv = 1'b1; tb_data = 32'h0; OE = 1'b0;
    #1;
    n_cmp++;
    if (DataBus !== 32'h0) begin
      n_bad++;
      $display("FAIL ts_wr_accept: bus=%h with probe 0, required 00000000", DataBus);
    end
    tick;
    n_cmp++;
    if (DataBus !== 32'h0) begin
      n_bad++;
      $display("FAIL ts_wr_commit: bus=%h with probe 0, required 00000000", DataBus);
    end
    tb_drv = 1'b0; OE = 1'b1;
    read_word(11'd23, d, v);
    n_cmp++;
    if (d !== 32'h0F0F_0F0F || v !== 1'b1) begin
      n_bad++;
      $display("FAIL ts_wr_data: valid=%b data=%h, required 1 0f0f0f0f", v, d);
    end
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] d;
    logic v;
    logic saw_valid = 1'b0;
    start_op(1'b0, 11'd9, 32'hAAAA_AAAA, 2'b11);
    RST = 1'b0;
    tick;
    n_cmp++;
    if (Valid !== 1'b0 || Ready !== 1'b0 || Busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_wr: Ready/Busy/Valid=%b%b%b, required 010", Ready, Busy, Valid);
    end
    tick;
    RST = 1'b1;
    wait_ready(3000);
    read_word(11'd9, d, v);
    n_cmp++;
    if (d !== 32'h0) begin
      n_bad++;
      $display("FAIL abort_addr9: data=%h, required 00000000", d);
    end
    read_word(11'd5, d, v);
    n_cmp++;
    if (d !== 32'h0) begin
      n_bad++;
      $display("FAIL reclear_addr5: data=%h, required 00000000", d);
    end
    read_word(11'h7FF, d, v);
    n_cmp++;
    if (d !== 32'h0) begin
      n_bad++;
      $display("FAIL reclear_top: data=%h, required 00000000", d);
    end
    write_word(11'd30, 32'h1212_1212, 2'b11);
    start_op(1'b1, 11'd30, '0, '0);
    RST = 1'b0;
    tick;
    if (Valid !== 1'b0) saw_valid = 1'b1;
    RST = 1'b1;
    for (int n = 0; n < 3000 && Ready !== 1'b1; n++) begin
      tick;
      if (Valid !== 1'b0) saw_valid = 1'b1;
    end
    n_cmp++;
    if (saw_valid !== 1'b0 || Ready !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_rd: Valid seen=%b Ready=%b, required 0 1", saw_valid, Ready);
    end
  endtask

  initial begin
    test_reset;
    test_full_rw;
    test_lanes;
    test_back_to_back;
    test_tristate;
    test_reset_mid_op;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
